// File: rtl/mb128_pkg.sv
// Shared types and protocol constants for the MB128 joypad-port memory host.
package mb128_pkg;

    typedef enum logic [3:0] {
        IDLE,
        SYNC,
        IDENT,
        REQ,
        ADDR,
        LENBITS,
        LENBYTES,
        DATA,
        TRAIL,
        FAIL
    } state_e;

    localparam logic [7:0] SYNC_BYTE  = 8'hA8;
    localparam int         ADDR_W     = 10;
    localparam int         BITS_W     = 3;
    localparam int         BYTES_W    = 17;
    localparam int         TRAIL_RD   = 3;
    localparam int         TRAIL_WR   = 5;
    localparam int         FAIL_SLOTS = 16;
    // Data slot count is {bytes, bits}, so the counter is the two fields side by side.
    localparam int         SLOT_W     = BYTES_W + BITS_W;

endpackage

// File: rtl/mb128_bit_timer.sv
// Bit-slot timer: HALF cycles low then HALF cycles high per slot, with
// slot-start, pre-rise and end-of-high-phase sample strobes.
module mb128_bit_timer #(
    parameter int HALF = 8
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic en_i,
    input  logic clk_en_i,
    output logic start_o,
    output logic rise_o,
    output logic sample_o,
    output logic mb_clk_o
);
    localparam int             CW   = $clog2(2 * HALF);
    localparam logic [CW-1:0]  MID  = CW'(HALF - 1);
    localparam logic [CW-1:0]  LAST = CW'(2 * HALF - 1);

    logic [CW-1:0] cnt_q;
    logic          ph_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            ph_q  <= 1'b0;
        end else if (!en_i) begin
            cnt_q <= '0;
            ph_q  <= 1'b0;
        end else begin
            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
            // clk_en_i low holds the line low for whole slots (device re-idle).
            if (cnt_q == MID)
                ph_q <= clk_en_i;
            else if (cnt_q == LAST)
                ph_q <= 1'b0;
        end
    end

    assign start_o  = en_i && (cnt_q == '0);
    assign rise_o   = en_i && clk_en_i && (cnt_q == MID);
    assign sample_o = en_i && (cnt_q == LAST);
    assign mb_clk_o = ph_q;

endmodule

// File: rtl/mb128_host.sv
// MB128 host: serialises sync/ident/header, moves DATA bits LSB-first through
// the joypad CLR/SEL lines, and closes with a trailer or a FAIL re-idle.
module mb128_host
    import mb128_pkg::*;
#(
    parameter int HALF = 8
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_write,
    input  logic [ADDR_W-1:0]  cmd_addr,
    input  logic [BITS_W-1:0]  cmd_bits,
    input  logic [BYTES_W-1:0] cmd_bytes,
    output logic               wr_req,
    input  logic [7:0]         wr_data,
    output logic               rd_valid,
    output logic [7:0]         rd_data,
    output logic               mb_clk,
    output logic               mb_data,
    input  logic [3:0]         mb_in,
    output logic               busy,
    output logic               done,
    output logic               err
);
    state_e              state_q, state_d;
    logic [SLOT_W-1:0]   cnt_q, len_d, data_len;
    logic                wr_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [BITS_W-1:0]   bits_q;
    logic [BYTES_W-1:0]  bytes_q;
    logic [7:0]          wbuf_q, rsh_q, rd_data_q, rfull_d, rpart_d;
    logic                mb_data_q, wr_req_q, rd_valid_q, done_q, err_q;
    logic                bit_d, slot_last;
    logic [2:0]          idx;
    logic [15:0]         addr_x;
    logic [3:0]          bits_x;
    logic [31:0]         bytes_x;
    logic                t_start, t_rise, t_sample;
    logic                unused_in;

    mb128_bit_timer #(.HALF(HALF)) u_tmr (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .en_i     (state_q != IDLE),
        .clk_en_i (state_q != FAIL),
        .start_o  (t_start),
        .rise_o   (t_rise),
        .sample_o (t_sample),
        .mb_clk_o (mb_clk)
    );

    assign unused_in = ^{mb_in[3], mb_in[1], t_rise};
    assign data_len  = {bytes_q, bits_q};
    assign idx       = cnt_q[2:0];
    assign addr_x    = {6'd0, addr_q};
    assign bits_x    = {1'b0, bits_q};
    assign bytes_x   = {15'd0, bytes_q};
    assign slot_last = (cnt_q == len_d - SLOT_W'(1));
    assign rfull_d   = {mb_in[0], rsh_q[7:1]};
    // A partial group lands in the top bits of the shifter; right-align it.
    assign rpart_d   = rfull_d >> (4'd8 - bits_x);

    always_comb begin
        len_d   = SLOT_W'(1);
        bit_d   = 1'b0;
        state_d = IDLE;
        unique case (state_q)
            SYNC:     begin len_d = SLOT_W'(8);       bit_d = SYNC_BYTE[idx];        state_d = IDENT;    end
            IDENT:    begin len_d = SLOT_W'(2);       bit_d = cnt_q[0];
                            state_d = mb_in[2] ? REQ : FAIL;                                             end
            REQ:      begin len_d = SLOT_W'(1);       bit_d = ~wr_q;                 state_d = ADDR;     end
            ADDR:     begin len_d = SLOT_W'(ADDR_W);  bit_d = addr_x[cnt_q[3:0]];    state_d = LENBITS;  end
            LENBITS:  begin len_d = SLOT_W'(BITS_W);  bit_d = bits_x[cnt_q[1:0]];    state_d = LENBYTES; end
            LENBYTES: begin len_d = SLOT_W'(BYTES_W); bit_d = bytes_x[cnt_q[4:0]];
                            state_d = (data_len == '0) ? TRAIL : DATA;                                   end
            DATA:     begin len_d = data_len;         bit_d = wr_q & wbuf_q[idx];    state_d = TRAIL;    end
            TRAIL:    len_d = wr_q ? SLOT_W'(TRAIL_WR) : SLOT_W'(TRAIL_RD);
            FAIL:     len_d = SLOT_W'(FAIL_SLOTS);
            default:  ;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            bits_q     <= '0;
            bytes_q    <= '0;
            wbuf_q     <= '0;
            rsh_q      <= '0;
            rd_data_q  <= '0;
            mb_data_q  <= 1'b0;
            wr_req_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            wr_req_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            if (state_q == IDLE) begin
                mb_data_q <= 1'b0;
                cnt_q     <= '0;
                if (cmd_valid) begin
                    if (cmd_write && cmd_bytes == '0 && cmd_bits == '0) begin
                        err_q <= 1'b1;
                    end else begin
                        wr_q    <= cmd_write;
                        addr_q  <= cmd_addr;
                        bits_q  <= cmd_bits;
                        bytes_q <= cmd_bytes;
                        state_q <= SYNC;
                    end
                end
            end else begin
                if (t_start) begin
                    // First slot of each write group: pop the FIFO, drive the bit a cycle later.
                    if (state_q == DATA && wr_q && idx == 3'd0) begin
                        wr_req_q  <= 1'b1;
                        mb_data_q <= 1'b0;
                    end else begin
                        mb_data_q <= bit_d;
                    end
                end
                if (wr_req_q) begin
                    wbuf_q    <= wr_data;
                    mb_data_q <= wr_data[0];
                end
                if (t_sample) begin
                    if (state_q == DATA && !wr_q) begin
                        rsh_q <= rfull_d;
                        if (idx == 3'd7) begin
                            rd_valid_q <= 1'b1;
                            rd_data_q  <= rfull_d;
                        end else if (slot_last) begin
                            rd_valid_q <= 1'b1;
                            rd_data_q  <= rpart_d;
                        end
                    end
                    if (slot_last) begin
                        cnt_q   <= '0;
                        state_q <= state_d;
                        if (state_q == TRAIL) done_q <= 1'b1;
                        if (state_q == FAIL)  err_q  <= 1'b1;
                        if (state_d == FAIL)  mb_data_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + SLOT_W'(1);
                    end
                end
            end
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign mb_data   = mb_data_q;
    assign wr_req    = wr_req_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_mb128_host.sv
// Directed bench for mb128_host with a behavioural MB128 device on the joypad lines.
module tb_mb128_host;
    localparam int HALF = 8;

    logic        clk_sys = 1'b0, reset_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_write = 1'b0;
    logic [9:0]  cmd_addr = '0;
    logic [2:0]  cmd_bits = '0;
    logic [16:0] cmd_bytes = '0;
    logic        cmd_ready, wr_req, rd_valid, mb_clk, mb_data, busy, done, err;
    logic [7:0]  wr_data, rd_data;
    logic [3:0]  mb_in;
    logic        ident_ok = 1'b1;
    logic        dev_bit = 1'b0;

    int n_chk = 0, n_fail = 0;

    logic [7:0] rom   [0:1023];
    logic [7:0] mem_w [0:1023];
    bit         wv    [0:1023];
    logic [7:0] wsrc  [0:63];
    logic [7:0] rbuf  [0:15];
    int         widx = 0, rcnt = 0, done_cnt = 0, err_cnt = 0;

    int          dn = 0, tot_rises = 0, dd, bi;
    time         last_rise = 0;
    logic [7:0]  dsync, cur;
    logic        dreq;
    logic [9:0]  daddr;
    logic [2:0]  dbits;
    logic [16:0] dbytes;

    mb128_host #(.HALF(HALF)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_bits(cmd_bits), .cmd_bytes(cmd_bytes),
        .wr_req(wr_req), .wr_data(wr_data), .rd_valid(rd_valid), .rd_data(rd_data),
        .mb_clk(mb_clk), .mb_data(mb_data), .mb_in(mb_in),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk_sys = ~clk_sys;

    assign mb_in   = {1'b0, ident_ok, 1'b0, dev_bit};
    assign wr_data = wsrc[widx % 64];

    // Show-ahead write FIFO: pops on the edge that samples wr_data.
    always @(posedge clk_sys) if (wr_req === 1'b1) widx <= widx + 1;

    always @(negedge clk_sys) begin
        if (rd_valid === 1'b1) begin
            rbuf[rcnt % 16] = rd_data;
            rcnt = rcnt + 1;
        end
        if (done === 1'b1) done_cnt = done_cnt + 1;
        if (err === 1'b1)  err_cnt  = err_cnt + 1;
    end

    // Device: a long gap between rises starts a new transaction.
    always @(posedge mb_clk) begin
        if ($time - last_rise > 200) dn = 0; else dn = dn + 1;
        last_rise = $time;
        tot_rises = tot_rises + 1;
        if (dn < 8)                   dsync[dn] = mb_data;
        else if (dn == 10)            dreq = mb_data;
        else if (dn >= 11 && dn < 21) daddr[dn-11] = mb_data;
        else if (dn >= 21 && dn < 24) dbits[dn-21] = mb_data;
        else if (dn >= 24 && dn < 41) dbytes[dn-24] = mb_data;
        else if (dn >= 41) begin
            dd = dn - 41;
            if (dd < int'({dbytes, dbits})) begin
                bi = int'(daddr) * 128 + dd / 8;
                if (dreq) begin
                    cur = wv[bi] ? mem_w[bi] : rom[bi];
                    dev_bit <= cur[dd % 8];
                end else begin
                    if (!wv[bi]) begin
                        mem_w[bi] = rom[bi];
                        wv[bi] = 1'b1;
                    end
                    mem_w[bi][dd % 8] = mb_data;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic issue(input logic w, input logic [9:0] a, input logic [2:0] b, input logic [16:0] n);
        @(negedge clk_sys);
        cmd_write = w; cmd_addr = a; cmd_bits = b; cmd_bytes = n; cmd_valid = 1'b1;
        @(negedge clk_sys);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_evt(input string tag, input bit use_err, input int start);
        int k = 0;
        while ((use_err ? err_cnt : done_cnt) == start && k < 4000) begin
            @(negedge clk_sys);
            k++;
        end
        chk(tag, 32'((use_err ? err_cnt : done_cnt) != start), 32'd1);
    endtask

    initial begin
        int d0, e0, r0, w0, t0, k;
        for (int i = 0; i < 1024; i++) rom[i] = 8'h00;
        rom[0] = 8'h5A; rom[640] = 8'hA5; rom[641] = 8'hFF;
        for (int i = 0; i < 64; i++) wsrc[i] = 8'h00;

        #1;
        chk("rst cmd_ready", cmd_ready, 1);
        chk("rst busy", busy, 0);
        chk("rst mb_clk", mb_clk, 0);
        chk("rst mb_data", mb_data, 0);
        chk("rst strobes", {done, err, rd_valid, wr_req}, 0);
        chk("rst rd_data", rd_data, 0);
        idle(3); reset_n = 1'b1; idle(30);

        // Read 1 byte at addr 0; a write 0/0 offered while busy must be ignored.
        d0 = done_cnt; e0 = err_cnt; r0 = rcnt;
        issue(0, 10'd0, 3'd0, 17'd1);
        idle(5);
        issue(1, 10'd0, 3'd0, 17'd0);
        wait_evt("t1 done", 0, d0);
        chk("t1 rd count", rcnt - r0, 1);
        chk("t1 rd data", rbuf[r0 % 16], 8'h5A);
        chk("t1 rises", dn + 1, 52);
        chk("t1 sync byte", dsync, 8'hA8);
        chk("t1 req bit", dreq, 1);
        chk("t1 busy cmd ignored", err_cnt - e0, 0);
        chk("t1 idle mb_clk", {mb_clk, cmd_ready}, 2'b01);
        idle(20);

        // Write 0x12,0x34 at addr 3, then read back.
        d0 = done_cnt; w0 = widx;
        wsrc[w0 % 64] = 8'h12; wsrc[(w0 + 1) % 64] = 8'h34;
        issue(1, 10'd3, 3'd0, 17'd2);
        wait_evt("t2 wr done", 0, d0);
        chk("t2 wr_req count", widx - w0, 2);
        chk("t2 dev addr", daddr, 3);
        chk("t2 mem byte0", mem_w[384], 8'h12);
        chk("t2 mem byte1", mem_w[385], 8'h34);
        chk("t2 wr rises", dn + 1, 62);
        idle(20);
        d0 = done_cnt; r0 = rcnt;
        issue(0, 10'd3, 3'd0, 17'd2);
        wait_evt("t2 rd done", 0, d0);
        chk("t2 rd count", rcnt - r0, 2);
        chk("t2 rd byte0", rbuf[r0 % 16], 8'h12);
        chk("t2 rd byte1", rbuf[(r0 + 1) % 16], 8'h34);
        chk("t2 rd rises", dn + 1, 60);
        idle(20);

        // Read 1 byte + 3 bits at addr 5.
        d0 = done_cnt; r0 = rcnt;
        issue(0, 10'd5, 3'd3, 17'd1);
        wait_evt("t3 done", 0, d0);
        chk("t3 rd count", rcnt - r0, 2);
        chk("t3 rd byte", rbuf[r0 % 16], 8'hA5);
        chk("t3 rd partial", rbuf[(r0 + 1) % 16], 8'h07);
        chk("t3 rises", dn + 1, 55);
        idle(20);

        // Partial-only write: 3 bits of 0xFD at addr 6.
        d0 = done_cnt; w0 = widx;
        wsrc[w0 % 64] = 8'hFD;
        issue(1, 10'd6, 3'd3, 17'd0);
        wait_evt("t4 done", 0, d0);
        chk("t4 wr_req count", widx - w0, 1);
        chk("t4 mem partial", mem_w[768], 8'h05);
        chk("t4 rises", dn + 1, 49);
        idle(20);

        // Zero-length read: header and trailer only.
        d0 = done_cnt; r0 = rcnt;
        issue(0, 10'd0, 3'd0, 17'd0);
        wait_evt("t5 done", 0, d0);
        chk("t5 no rd_valid", rcnt - r0, 0);
        chk("t5 rises", dn + 1, 44);
        idle(20);

        // Device absent: ident bit low -> FAIL re-idle then err.
        ident_ok = 1'b0;
        d0 = done_cnt; e0 = err_cnt;
        issue(0, 10'd1, 3'd0, 17'd1);
        wait_evt("t6 err", 1, e0);
        chk("t6 rises", dn + 1, 10);
        chk("t6 no done", done_cnt - d0, 0);
        chk("t6 idle", {cmd_ready, busy, mb_clk, mb_data}, 4'b1000);
        ident_ok = 1'b1;
        idle(20);

        // Rejected empty write: err next cycle, no clock activity.
        t0 = tot_rises;
        issue(1, 10'd0, 3'd0, 17'd0);
        chk("t7 err pulse", err, 1);
        chk("t7 not busy", busy, 0);
        idle(40);
        chk("t7 no rises", tot_rises - t0, 0);
        idle(20);

        // Reset during DATA slot 5 of a read.
        issue(0, 10'd0, 3'd0, 17'd1);
        k = 0;
        while (dn != 46 && k < 3000) begin
            @(negedge clk_sys);
            k++;
        end
        chk("t8 reached data slot", dn, 46);
        reset_n = 1'b0;
        #1;
        chk("t8 rst outputs", {mb_clk, mb_data, busy, done, err, rd_valid, wr_req}, 0);
        chk("t8 rst rd_data", rd_data, 0);
        chk("t8 rst cmd_ready", cmd_ready, 1);
        idle(2);
        reset_n = 1'b1;
        r0 = rcnt; w0 = widx;
        idle(60);
        chk("t8 no stray strobes", (rcnt - r0) + (widx - w0), 0);
        d0 = done_cnt; r0 = rcnt;
        issue(0, 10'd0, 3'd0, 17'd1);
        wait_evt("t8 done", 0, d0);
        chk("t8 rd count", rcnt - r0, 1);
        chk("t8 rd data", rbuf[r0 % 16], 8'h5A);
        chk("t8 rises", dn + 1, 52);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mb128_host.md
MB128_HOST -- requirements
Module: mb128_host

Interface
REQ-001 Parameter HALF, default 8, clk_sys cycles per half bit-period (mb_clk low phase = high phase = HALF cycles, HALF >= 4).
REQ-002 clk_sys  in  1  system clock; the block's only clock.
REQ-003 reset_n  in  1  reset, asynchronous, active-low.
REQ-004 cmd_valid  in  1  command request; cmd_ready  out  1  high only in IDLE; transfer accepted when both high.
REQ-005 cmd_write  in  1  1 = write, 0 = read; cmd_addr  in  10  address in 128-byte units; cmd_bits  in  3  trailing partial-byte bit count; cmd_bytes  in  17  whole-byte count.
REQ-006 wr_req  out  1  one-cycle pop of next write byte; wr_data  in  8  show-ahead, sampled in the wr_req cycle.
REQ-007 rd_valid  out  1  one-cycle strobe; rd_data  out  8  read byte (LSB-first assembled).
REQ-008 mb_clk  out  1  joypad CLR line to device; mb_data  out  1  joypad SEL line to device; mb_in  in  4  device nibble (bit0 = data, bit2 = ident).
REQ-009 busy  out  1  transaction in progress; done  out  1  one-cycle success pulse; err  out  1  one-cycle ident-failure or rejected-command pulse.

Function
REQ-010 Every bit slot: mb_data set at slot start, mb_clk low HALF cycles then high HALF cycles; device samples mb_data on mb_clk rise.
REQ-011 mb_in is sampled in the last cycle of each high phase, never earlier.
REQ-012 FSM states: IDLE, SYNC, IDENT, REQ, ADDR, LENBITS, LENBYTES, DATA, TRAIL, FAIL.
REQ-013 SYNC: 8 slots sending 0xA8 LSB-first (0,0,0,1,0,1,0,1).
REQ-014 IDENT: 2 slots, sending 0 then 1; after slot 2, mb_in[2] SHALL be 1, else go to FAIL.
REQ-015 REQ: 1 slot sending ~cmd_write (1 = read).
REQ-016 ADDR 10 slots, LENBITS 3 slots, LENBYTES 17 slots; all fields LSB-first from values latched at acceptance; header totals 41 slots.
REQ-017 DATA length = 8*cmd_bytes + cmd_bits slots; byte boundaries every 8 slots, then the partial-bit slots.
REQ-018 Write DATA: wr_req pulses once at the start of each byte (and once for a nonzero partial group); bits sent LSB-first; partial group sends wr_data[cmd_bits-1:0].
REQ-019 Read DATA: mb_in[0] shifted in LSB-first; rd_valid pulses the cycle after the 8th sample, and after the last partial bit with upper bits zero.
REQ-020 TRAIL: mb_data = 0; 3 slots for read, 5 slots for write; then done pulse, return to IDLE with mb_clk = 0.
REQ-021 Write with cmd_bytes = 0 and cmd_bits = 0: rejected at acceptance, err pulse, no mb_clk activity; read with both zero: header then trailer only.
REQ-022 FAIL: mb_clk = 0, mb_data = 0 for 16 slot-times (device re-idles), err pulse, then IDLE.
REQ-023 cmd_valid is ignored while busy; cmd_bytes max 0x1FFFF is legal with no counter wrap.
REQ-024 Counters: slot counter 17+3-bit wide enough for 8*0x1FFFF+7 data slots.

Reset
REQ-025 Asynchronous assertion: state IDLE, mb_clk = 0, mb_data = 0, busy/done/err/rd_valid/wr_req = 0, rd_data = 0, cmd_ready = 1 after release.
REQ-026 Reset mid-transaction aborts immediately; no partial rd_valid or wr_req after release.

Structure
REQ-027 Package mb128_pkg holds the FSM state enum, SYNC byte 0xA8, field widths (10/3/17) and trailer lengths (3/5).
REQ-028 One sub-module, mb128_bit_timer, produces slot-start, rise and sample strobes from HALF.

Verification
REQ-029 Read addr 0, bytes 1, bits 0, device memory[0] = 0x5A -> rd_valid once with 0x5A, 52 mb_clk rises, done.
REQ-030 Write addr 3, 2 bytes 0x12,0x34, then read same -> two wr_req, readback 0x12, 0x34.
REQ-031 Read bytes 1, bits 3, memory = 0xA5,0xFF -> rd_data 0xA5 then 0x07.
REQ-032 mb_in tied to 0 -> err after 10 rises, no ADDR slots, back to IDLE.
REQ-033 Write bytes 0 bits 0 -> err next cycle, no mb_clk edge.
REQ-034 reset_n low during DATA slot 5 -> all outputs reset values; following read returns correct data.
